// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller. Drives the trial (B) operand
// of an external combinational magnitude comparator, reads back the
// lesser/greater/equal flags in the same cycle and binary-searches the
// unknown A operand MSB first.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; trial/result/found/error hold
// S_TEST | one cycle per bit; trial presented, flags evaluated
// S_FIN  | done pulse for one cycle, busy drops on exit

module sar_search_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_lesser,
    input  logic             cmp_greater,
    input  logic             cmp_equal,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             error
);

    // bit index needs at least one bit even for a single-step search
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TEST = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_trial, w_trial_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic [IW-1:0]    r_bit_idx, w_bit_idx_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_found, w_found_nxt;
    logic             r_error, w_error_nxt;
    logic [WIDTH-1:0] w_bit_mask;
    logic [WIDTH-1:0] w_kept;
    logic             w_onehot;

    assign w_bit_mask = ONE << r_bit_idx;
    assign w_onehot   = $onehot({cmp_lesser, cmp_greater, cmp_equal});
    // a "lesser" answer means the bit under test overshot A and must be dropped
    assign w_kept     = cmp_lesser ? (r_trial & ~w_bit_mask) : r_trial;

    // state and datapath registers; reset clears everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_trial   <= '0;
            r_result  <= '0;
            r_bit_idx <= '0;
            r_busy    <= 1'b0;
            r_found   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_trial   <= w_trial_nxt;
            r_result  <= w_result_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_busy    <= w_busy_nxt;
            r_found   <= w_found_nxt;
            r_error   <= w_error_nxt;
        end
    end

    // next-state and next-datapath decode
    always_comb begin
        w_state_nxt   = r_state;
        w_trial_nxt   = r_trial;
        w_result_nxt  = r_result;
        w_bit_idx_nxt = r_bit_idx;
        w_busy_nxt    = r_busy;
        w_found_nxt   = r_found;
        w_error_nxt   = r_error;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_trial_nxt   = MSB;
                    w_bit_idx_nxt = IW'(WIDTH - 1);
                    w_busy_nxt    = 1'b1;
                    w_found_nxt   = 1'b0;
                    w_error_nxt   = 1'b0;
                    w_result_nxt  = '0;
                    w_state_nxt   = S_TEST;
                end
            end
            S_TEST: begin
                if (!w_onehot) begin
                    w_error_nxt  = 1'b1;
                    w_result_nxt = '0;
                    w_state_nxt  = S_FIN;
                end else if (cmp_equal) begin
                    w_result_nxt = r_trial;
                    w_found_nxt  = 1'b1;
                    w_state_nxt  = S_FIN;
                end else if (r_bit_idx != '0) begin
                    w_trial_nxt   = w_kept | (w_bit_mask >> 1);
                    w_bit_idx_nxt = r_bit_idx - IW'(1);
                end else if (cmp_lesser) begin
                    w_result_nxt = w_kept;
                    w_found_nxt  = 1'b1;
                    w_state_nxt  = S_FIN;
                end else begin
                    // greater on the last bit: no consistent A exists
                    w_error_nxt  = 1'b1;
                    w_result_nxt = '0;
                    w_state_nxt  = S_FIN;
                end
            end
            S_FIN: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign trial  = r_trial;
    assign busy   = r_busy;
    assign done   = (r_state == S_FIN);
    assign result = r_result;
    assign found  = r_found;
    assign error  = r_error;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl with WIDTH=3. The comparator is modelled from A
// and trial, with forced-flag modes for the inconsistent-comparator cases.
// Expected results come from closed-form binary-search arithmetic.

module tb_sar_search_ctrl;

    localparam int W = 3;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         cmp_lesser, cmp_greater, cmp_equal;
    logic [W-1:0] trial;
    logic         busy, done;
    logic [W-1:0] result;
    logic         found, error;

    logic [W-1:0] a_val;
    int           cmp_mode;   // 0 normal, 1 no flags, 2 always greater, 3 lesser+greater
    int           n_cmp;
    int           n_err;
    logic [W-1:0] trials[$];

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cmp_lesser  (cmp_lesser),
        .cmp_greater (cmp_greater),
        .cmp_equal   (cmp_equal),
        .trial       (trial),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .found       (found),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cmp_lesser  = 1'b0;
        cmp_greater = 1'b0;
        cmp_equal   = 1'b0;
        case (cmp_mode)
            0: begin
                cmp_lesser  = (a_val < trial);
                cmp_greater = (a_val > trial);
                cmp_equal   = (a_val == trial);
            end
            2: cmp_greater = 1'b1;
            3: begin
                cmp_lesser  = 1'b1;
                cmp_greater = 1'b1;
            end
            default: ;
        endcase
    end

    // number of TEST cycles: search stops at the lowest set bit of A
    function automatic int n_tests(int a);
        if (a == 0) return W;
        for (int i = 0; i < W; i++)
            if (((a >> i) & 1) == 1) return W - i;
        return W;
    endfunction

    // trial at a given step: A's bits above the tested position plus the tested bit
    function automatic int exp_trial(int a, int step);
        int p;
        p = W - 1 - step;
        return ((a >> (p + 1)) << (p + 1)) | (1 << p);
    endfunction

    // pulse start, then count negedges until done (bounded); records trials
    task automatic run_search(output int lat, output bit got, output bit busy_ok,
                              output logic [W-1:0] res, output logic fnd, output logic err);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        lat = 0; got = 1'b0; busy_ok = 1'b1; res = '0; fnd = 1'b0; err = 1'b0;
        trials.delete();
        for (int c = 1; c <= 20; c++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = c; got = 1'b1;
                res = result; fnd = found; err = error;
                break;
            end
            trials.push_back(trial);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a_val = '0; cmp_mode = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({trial, busy, done, result, found, error} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got %b want 0", {trial, busy, done, result, found, error});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++; $display("FAIL idle_after_reset busy/done got %b want 00", {busy, done});
        end
    endtask

    task automatic test_directed();
        int lat; bit got, bok; logic [W-1:0] res; logic fnd, err;
        int exp5[3] = '{4, 6, 5};
        int exp0[3] = '{4, 2, 1};
        int exp7[3] = '{4, 6, 7};
        cmp_mode = 0;

        a_val = 3'd5;
        run_search(lat, got, bok, res, fnd, err);
        n_cmp++; if (!got || lat != 4) begin n_err++; $display("FAIL a5_latency got %0d want 4", lat); end
        n_cmp++; if ({res, fnd, err} !== {3'd5, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL a5_result got r=%0d f=%b e=%b want r=5 f=1 e=0", res, fnd, err); end
        n_cmp++; if (!bok) begin n_err++; $display("FAIL a5_busy got 0 want 1"); end
        n_cmp++; if (trials.size() != 3) begin n_err++; $display("FAIL a5_ntrials got %0d want 3", trials.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (trials[i] !== 3'(exp5[i])) begin
                n_err++; $display("FAIL a5_trial%0d got %0d want %0d", i, trials[i], exp5[i]); end
        end

        a_val = 3'd4;
        run_search(lat, got, bok, res, fnd, err);
        n_cmp++; if (!got || lat != 2) begin n_err++; $display("FAIL a4_latency got %0d want 2", lat); end
        n_cmp++; if ({res, fnd, err} !== {3'd4, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL a4_result got r=%0d f=%b e=%b want r=4 f=1 e=0", res, fnd, err); end

        a_val = 3'd0;
        run_search(lat, got, bok, res, fnd, err);
        n_cmp++; if (!got || lat != 4) begin n_err++; $display("FAIL a0_latency got %0d want 4", lat); end
        n_cmp++; if ({res, fnd, err} !== {3'd0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL a0_result got r=%0d f=%b e=%b want r=0 f=1 e=0", res, fnd, err); end
        n_cmp++; if (trials.size() != 3) begin n_err++; $display("FAIL a0_ntrials got %0d want 3", trials.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (trials[i] !== 3'(exp0[i])) begin
                n_err++; $display("FAIL a0_trial%0d got %0d want %0d", i, trials[i], exp0[i]); end
        end

        a_val = 3'd7;
        run_search(lat, got, bok, res, fnd, err);
        n_cmp++; if (!got || lat != 4) begin n_err++; $display("FAIL a7_latency got %0d want 4", lat); end
        n_cmp++; if ({res, fnd, err} !== {3'd7, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL a7_result got r=%0d f=%b e=%b want r=7 f=1 e=0", res, fnd, err); end
        n_cmp++; if (trials.size() != 3) begin n_err++; $display("FAIL a7_ntrials got %0d want 3", trials.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (trials[i] !== 3'(exp7[i])) begin
                n_err++; $display("FAIL a7_trial%0d got %0d want %0d", i, trials[i], exp7[i]); end
        end
        @(negedge clk);
        n_cmp++; if ({done, busy, result, found, trial} !== {1'b0, 1'b0, 3'd7, 1'b1, 3'd7}) begin
            n_err++; $display("FAIL a7_hold got d=%b b=%b r=%0d f=%b t=%0d want d=0 b=0 r=7 f=1 t=7",
                              done, busy, result, found, trial); end
    endtask

    task automatic test_error();
        int lat; bit got, bok; logic [W-1:0] res; logic fnd, err;
        a_val = 3'd5;

        cmp_mode = 1;
        run_search(lat, got, bok, res, fnd, err);
        n_cmp++; if (!got || lat != 2) begin n_err++; $display("FAIL noflag_latency got %0d want 2", lat); end
        n_cmp++; if ({res, fnd, err} !== {3'd0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL noflag_result got r=%0d f=%b e=%b want r=0 f=0 e=1", res, fnd, err); end

        cmp_mode = 2;
        run_search(lat, got, bok, res, fnd, err);
        n_cmp++; if (!got || lat != 4) begin n_err++; $display("FAIL gt_bit0_latency got %0d want 4", lat); end
        n_cmp++; if ({res, fnd, err} !== {3'd0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL gt_bit0_result got r=%0d f=%b e=%b want r=0 f=0 e=1", res, fnd, err); end

        cmp_mode = 3;
        run_search(lat, got, bok, res, fnd, err);
        n_cmp++; if (!got || lat != 2) begin n_err++; $display("FAIL multiflag_latency got %0d want 2", lat); end
        n_cmp++; if ({res, fnd, err} !== {3'd0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL multiflag_result got r=%0d f=%b e=%b want r=0 f=0 e=1", res, fnd, err); end
        cmp_mode = 0;
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        cmp_mode = 0; a_val = 3'd5;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;   // first TEST cycle
        @(negedge clk);                 // second TEST cycle
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({trial, busy, done, result, found, error} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs got %b want 0", {trial, busy, done, result, found, error});
        end
        saw_done = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done) begin n_err++; $display("FAIL reset_mid_no_done got done/busy=1 want 0"); end
    endtask

    task automatic test_busy_ignore();
        int lat; bit got;
        cmp_mode = 0; a_val = 3'd3;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        lat = 0; got = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (done) begin lat = c; got = 1'b1; break; end
            start = (c == 2);
            @(negedge clk);
        end
        n_cmp++; if (!got || lat != 4) begin n_err++; $display("FAIL busy_ignore_latency got %0d want 4", lat); end
        n_cmp++; if ({result, found} !== {3'd3, 1'b1}) begin
            n_err++; $display("FAIL busy_ignore_result got r=%0d f=%b want r=3 f=1", result, found); end
        start = 1'b1;                   // during the done cycle
        @(negedge clk); start = 1'b0;
        n_cmp++; if ({busy, done} !== 2'b00) begin
            n_err++; $display("FAIL start_in_done got busy/done=%b want 00", {busy, done}); end
        @(negedge clk);
        n_cmp++; if ({busy, done} !== 2'b00) begin
            n_err++; $display("FAIL start_in_done_late got busy/done=%b want 00", {busy, done}); end
    endtask

    task automatic test_back_to_back();
        int lat; bit got, bok; logic [W-1:0] res; logic fnd, err;
        cmp_mode = 0;
        a_val = 3'd6;
        run_search(lat, got, bok, res, fnd, err);
        n_cmp++; if (!got || lat != 3 || res !== 3'd6) begin
            n_err++; $display("FAIL b2b_first got lat=%0d r=%0d want lat=3 r=6", lat, res); end
        a_val = 3'd1;
        run_search(lat, got, bok, res, fnd, err);
        n_cmp++; if (!got || lat != 4) begin n_err++; $display("FAIL b2b_second_latency got %0d want 4", lat); end
        n_cmp++; if ({res, fnd, err} !== {3'd1, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL b2b_second_result got r=%0d f=%b e=%b want r=1 f=1 e=0", res, fnd, err); end
    endtask

    task automatic test_random();
        int lat; bit got, bok; logic [W-1:0] res; logic fnd, err;
        int mode, a, e_lat, e_res, e_nt;
        logic e_fnd, e_err;
        for (int it = 0; it < 40; it++) begin
            a    = int'($urandom_range(0, (1 << W) - 1));
            mode = int'($urandom_range(0, 5));
            if (mode > 2) cmp_mode = mode - 2; else cmp_mode = 0;
            a_val = W'(a);
            case (cmp_mode)
                0: begin e_nt = n_tests(a); e_res = a; e_fnd = 1'b1; e_err = 1'b0; end
                2: begin e_nt = W; e_res = 0; e_fnd = 1'b0; e_err = 1'b1; end
                default: begin e_nt = 1; e_res = 0; e_fnd = 1'b0; e_err = 1'b1; end
            endcase
            e_lat = e_nt + 1;
            run_search(lat, got, bok, res, fnd, err);
            n_cmp++;
            if (!got || lat != e_lat || res !== W'(e_res) || fnd !== e_fnd || err !== e_err || !bok) begin
                n_err++;
                $display("FAIL rand%0d a=%0d mode=%0d got lat=%0d r=%0d f=%b e=%b busy_ok=%b want lat=%0d r=%0d f=%b e=%b",
                         it, a, cmp_mode, lat, res, fnd, err, bok, e_lat, e_res, e_fnd, e_err);
            end
            n_cmp++;
            if (fnd && err) begin n_err++; $display("FAIL rand%0d found_and_error got 11 want not both", it); end
            if (cmp_mode == 0 && trials.size() == e_nt) begin
                for (int s = 0; s < e_nt; s++) begin
                    n_cmp++;
                    if (trials[s] !== W'(exp_trial(a, s))) begin
                        n_err++;
                        $display("FAIL rand%0d trial%0d got %0d want %0d", it, s, trials[s], exp_trial(a, s));
                    end
                end
            end else if (cmp_mode == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rand%0d ntrials got %0d want %0d", it, trials.size(), e_nt);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        cmp_mode = 0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        test_reset();
        test_directed();
        test_error();
        test_reset_mid();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
